// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite UART master path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// AXI_DATA_WIDTH_UART : byte width carried over the serial link.
// uart_tx_state_t     : frame sequencer states, shared by the TX and RX blocks.
package axil_pkg;

  localparam int AXI_DATA_WIDTH_UART = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage : axil_pkg

// File: rtl/axis_if_uart.sv
// Byte-wide AXI-Stream link used between the AXI-Lite bridge and the UART.
// Latency: n/a (wires only).
// Backpressure: standard valid/ready; a beat moves when tvalid && tready.
//
// tdata  : one byte, LSB is the first bit on the line.
// tvalid : producer has a byte.
// tready : consumer can take a byte this cycle.
interface axis_if_uart;

  logic [axil_pkg::AXI_DATA_WIDTH_UART-1:0] tdata;
  logic                                     tvalid;
  logic                                     tready;

  modport s_axis (
    input  tdata,
    input  tvalid,
    output tready
  );

  modport m_axis (
    output tdata,
    output tvalid,
    input  tready
  );

endinterface : axis_if_uart

// File: rtl/uart_tx_axis.sv
// 8N1 UART transmitter fed by a byte-wide AXI-Stream slave.
// Latency: handshake in cycle N puts the start bit on tx in cycle N+1; a frame is 10*BAUD_DIV cycles.
// Backpressure: tready only in IDLE or the last stop-bit cycle; back-to-back frames are gapless.
//
// Ports:
//   aclk    : sole clock
//   areset  : synchronous, active-high reset (aborts any frame in flight)
//   s_axis  : byte input (tdata / tvalid / tready)
//   tx      : serial line, idles high, registered
//   busy    : high while START, DATA or STOP is on the line, registered
module uart_tx_axis
  import axil_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic        aclk,
  input  logic        areset,
  axis_if_uart.s_axis s_axis,
  output logic        tx,
  output logic        busy
);

  // Bit period in clocks, rounded to the nearest integer. No fractional
  // accumulation: the residual error is accepted as part of the baud tolerance.
  localparam int BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int DW       = AXI_DATA_WIDTH_UART;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       BIT_LAST = 3'd7;

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_axis: BAUD_DIV must be at least 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  uart_tx_state_t   state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       bit_q,    bit_d;
  logic [DW-1:0]    shift_q,  shift_d;
  logic             tx_q,     tx_d;
  logic             busy_q,   busy_d;

  logic             tready_int;
  logic             hs;
  logic             bit_end;

  // --------------------------------------------------------------------------
  // Ready decode: registered state and counter only, so there is no
  // combinational path from tvalid to tready. Forced low during reset so a
  // byte presented alongside reset is never accepted.
  // --------------------------------------------------------------------------
  always_comb begin
    tready_int = 1'b0;
    if (!areset) begin
      case (state_q)
        IDLE:    tready_int = 1'b1;
        STOP:    tready_int = (cnt_q == CNT_LAST);
        default: tready_int = 1'b0;
      endcase
    end
  end

  assign s_axis.tready = tready_int;
  assign hs            = s_axis.tvalid && tready_int;
  assign bit_end       = (cnt_q == CNT_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          shift_d = s_axis.tdata;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[DW-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // A byte taken in the last stop cycle goes straight to START so the
          // next start bit follows with no idle gap.
          if (hs) begin
            shift_d = s_axis.tdata;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Line level is a function of where the FSM will be next cycle, which
    // makes tx a clean flop output aligned with state_q.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // --------------------------------------------------------------------------
  // Registers: FSM, baud counter, bit index, shift register and outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule : uart_tx_axis

// File: tb/tb_uart_tx_axis.sv
// Directed bench for uart_tx_axis at BAUD_DIV = 10.
// Stimulus changes on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_axis;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BDIV      = 10;

  logic aclk;
  logic areset;
  logic tx;
  logic busy;

  axis_if_uart s_axis_if ();

  uart_tx_axis #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s_axis_if),
    .tx     (tx),
    .busy   (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one byte for one cycle; returns at the first start-bit cycle.
  task automatic send_byte(input string tag, input logic [7:0] b);
    check({tag, " ready before handshake"}, 32'(s_axis_if.tready), 32'd1);
    s_axis_if.tvalid = 1'b1;
    s_axis_if.tdata  = b;
    @(negedge aclk);
    s_axis_if.tvalid = 1'b0;
  endtask

  // Walks one full frame starting at the current (first start-bit) cycle.
  // Every cycle must show the expected line level with busy high; data bits are
  // decoded at mid-bit. Returns at the cycle right after the last stop cycle.
  task automatic expect_frame(input string tag, input logic [7:0] b, input bit toggle,
                              output logic rdy_last, output int rdy_early);
    logic [9:0] frame;
    logic [7:0] dec;
    int         bad;
    frame     = {1'b1, b, 1'b0};
    dec       = '0;
    bad       = 0;
    rdy_last  = 1'b0;
    rdy_early = 0;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < BDIV; c++) begin
        if (tx !== frame[k] || busy !== 1'b1) bad++;
        if (c == BDIV / 2 && k >= 1 && k <= 8) dec[k-1] = tx;
        if (k == 9 && c == BDIV - 1) rdy_last = s_axis_if.tready;
        else if (s_axis_if.tready === 1'b1) rdy_early++;
        @(negedge aclk);
        if (toggle) s_axis_if.tdata = ~s_axis_if.tdata;
      end
    end
    check({tag, " byte"}, 32'(dec), 32'(b));
    check({tag, " bad cycles"}, 32'(bad), 32'd0);
  endtask

  logic rdy_last;
  int   rdy_early;
  int   bad;

  initial begin
    areset           = 1'b1;
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tdata  = '0;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst tx", 32'(tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst tready", 32'(s_axis_if.tready), 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("idle tready", 32'(s_axis_if.tready), 32'd1);

    // Single byte 0x55
    send_byte("t55", 8'h55);
    check("t55 latency tx", 32'(tx), 32'd0);
    check("t55 latency busy", 32'(busy), 32'd1);
    expect_frame("t55", 8'h55, 1'b0, rdy_last, rdy_early);
    check("t55 no early ready", 32'(rdy_early), 32'd0);
    check("t55 post tready", 32'(s_axis_if.tready), 32'd1);
    check("t55 post busy", 32'(busy), 32'd0);
    check("t55 post tx", 32'(tx), 32'd1);

    // Back-to-back 0xA3, 0x00 with tvalid held high
    check("b2b ready", 32'(s_axis_if.tready), 32'd1);
    s_axis_if.tvalid = 1'b1;
    s_axis_if.tdata  = 8'hA3;
    @(negedge aclk);
    s_axis_if.tdata  = 8'h00;
    expect_frame("b2b f1", 8'hA3, 1'b0, rdy_last, rdy_early);
    check("b2b f1 ready cycle 99", 32'(rdy_last), 32'd1);
    check("b2b f1 ready early", 32'(rdy_early), 32'd0);
    s_axis_if.tvalid = 1'b0;
    expect_frame("b2b f2", 8'h00, 1'b0, rdy_last, rdy_early);
    check("b2b idle busy", 32'(busy), 32'd0);

    // Stall for 37 cycles after reset, then 0xFF
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge aclk);
    end
    check("stall line quiet", 32'(bad), 32'd0);
    send_byte("tff", 8'hFF);
    expect_frame("tff", 8'hFF, 1'b0, rdy_last, rdy_early);

    // tdata toggled every cycle during a 0x3C frame
    send_byte("t3c", 8'h3C);
    expect_frame("t3c", 8'h3C, 1'b1, rdy_last, rdy_early);

    // Reset in cycle 45 of a 0x81 frame, then 0x7E
    send_byte("t81", 8'h81);
    repeat (45) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    check("midrst tx", 32'(tx), 32'd1);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst tready low", 32'(s_axis_if.tready), 32'd0);
    areset = 1'b0;
    #1;
    check("midrst tready after", 32'(s_axis_if.tready), 32'd1);
    send_byte("t7e", 8'h7E);
    expect_frame("t7e", 8'h7E, 1'b0, rdy_last, rdy_early);

    // Reset coincident with tvalid
    areset           = 1'b1;
    s_axis_if.tvalid = 1'b1;
    s_axis_if.tdata  = 8'h00;
    #1;
    check("rstvld tready", 32'(s_axis_if.tready), 32'd0);
    @(negedge aclk);
    areset           = 1'b0;
    s_axis_if.tvalid = 1'b0;
    check("rstvld tx", 32'(tx), 32'd1);
    check("rstvld busy", 32'(busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge aclk);
    end
    check("rstvld no frame", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_tx_axis

// File: doc/uart_tx_axis.md
# uart_tx_axis

Serial UART transmitter for the AXI-Lite UART master path. Accepts bytes on an AXI-Stream slave port of type `axis_if_uart` and drives them onto the `tx` line as 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It carries AXI-Lite response data back to the host over the serial link.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000, clock frequency in Hz.
- `BAUD_RATE`, 115_200, line rate in bit/s.
- `BAUD_DIV` (localparam): (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE, i.e. rounded to nearest. Elaboration error if `BAUD_DIV` < 2.

Ports:
- `aclk`  input  1  sole clock. The block has one clock; reset is synchronous and active-high.
- `areset`  input  1  synchronous, active-high reset.
- `s_axis`  interface  `axis_if_uart.s_axis`  byte input.
  - `tdata` is `AXI_DATA_WIDTH_UART` bits wide (8).
  - `tvalid` input, `tready` output.
- `tx`  output  1  serial line. Idle level is high.
- `busy`  output  1  high while a frame is on the line (START, DATA or STOP state).

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1, `busy`=0, `tready`=1.
  - On `tvalid && tready`: latch `tdata` into the shift register, clear the baud counter and bit index, go to START.
- START: `tx`=0 for `BAUD_DIV` cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - After each `BAUD_DIV` cycles: shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- STOP:
  - `tx`=1 for `BAUD_DIV` cycles, then go to IDLE.
  - `tready` is also asserted in the last STOP cycle (baud counter = `BAUD_DIV`-1). A handshake there goes directly to START, giving gapless back-to-back frames.
- `tready` is decoded from registered state and counter only. It never depends on `tvalid`.
- Once latched, `tdata` is not sampled again. Changes on `tdata`/`tvalid` during a frame have no effect.
- Baud counter:
  - Width is $clog2(BAUD_DIV).
  - Counts 0..BAUD_DIV-1 and wraps to 0 at each bit boundary. No fractional accumulation.
- Bit index: 3 bits, 0..7.

## Timing
- Reset values: `tx`=1, `busy`=0, state=IDLE, counters=0, shift register=0.
- `tready`=0 in any cycle where `areset`=1.
- Reset mid-frame: `tx` returns to 1 on the next edge and the in-flight byte is discarded. There is no partial-frame completion.
- `tx` and `busy` are registered outputs.
- Latency: handshake at edge N, then `tx`=0 and `busy`=1 from edge N+1.
- Frame length is exactly 10×`BAUD_DIV` cycles, from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back frames: the next start bit begins the cycle after the last stop-bit cycle. Throughput is one byte per 10×`BAUD_DIV` cycles.
- Without an overlapping handshake, `tready` is high from the first IDLE cycle after STOP.
- `areset` and a handshake in the same cycle: reset wins and the byte is not accepted. `tready` is 0 in that cycle, so no handshake occurs.

## Structure
- `axil_pkg`:
  - Holds `AXI_DATA_WIDTH_UART` (existing).
  - Add `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t`, shared with the matching RX block.
- No sub-module. Baud counter, bit index and shift register live in a single always_ff block, with a separate always_comb for `tready`.

## Test plan
Bench parameters: CLK_FREQ=1_000_000 and BAUD_RATE=100_000, so `BAUD_DIV`=10.
- Single byte 0x55, `tvalid` one cycle:
  - `tx` is 0 for 10 cycles, then 1,0,1,0,1,0,1,0 (10 cycles each), then 1 for 10 cycles. Total 100 cycles.
  - `busy` is high for 100 cycles, then `tready`=1.
- Back-to-back 0xA3 then 0x00 with `tvalid` held high:
  - Second handshake occurs in cycle 99 of frame 1, and the second start bit begins in cycle 100 with no idle gap.
  - Decoded bytes are 0xA3 then 0x00.
- Stall: `tvalid` low for 37 cycles after reset:
  - `tx` stays 1 and `busy` stays 0.
  - Then 0xFF: start bit, eight 1-bits, stop bit.
- `tdata` toggled every cycle during a 0x3C frame: serialized byte is still 0x3C.
- Reset mid-frame:
  - Assert `areset` in cycle 45 of a 0x81 frame.
  - Next cycle: `tx`=1, `busy`=0. `tready`=1 after reset deasserts.
  - Next byte 0x7E is sent correctly.
- Reset coincident with `tvalid`: no frame starts and `tx` stays 1.
